// File: rtl/sb_rx_deserializer_pkg.sv
// sb_rx_pkg: shared types and default sizes for the sideband RX deserializer.
package sb_rx_pkg;
    typedef enum logic [1:0] {IDLE, RECEIVE, GAP} state_t;
    localparam int SB_PKT_W      = 64;
    localparam int SB_GAP_CYCLES = 32;
endpackage

// File: rtl/sb_rx_deserializer_if.sv
// sb_rx_deserializer_if: serial line in, parallel word and status strobes out.
interface sb_rx_deserializer_if import sb_rx_pkg::*; #(
    parameter int DATA_WIDTH = SB_PKT_W
);
    logic                  i_enable;
    logic                  RXDATASB;
    logic                  i_rx_valid;
    logic [DATA_WIDTH-1:0] o_data_out;
    logic                  o_de_ser_done;
    logic                  o_frame_error;
    logic                  o_gap_error;
    modport master (
        output i_enable, RXDATASB, i_rx_valid,
        input  o_data_out, o_de_ser_done, o_frame_error, o_gap_error
    );
    modport slave (
        input  i_enable, RXDATASB, i_rx_valid,
        output o_data_out, o_de_ser_done, o_frame_error, o_gap_error
    );
endinterface

// File: rtl/sb_rx_deserializer.sv
// sb_rx_deserializer: MSB-first sideband packet assembly with idle-gap enforcement.
module sb_rx_deserializer import sb_rx_pkg::*; #(
    parameter int DATA_WIDTH = SB_PKT_W,
    parameter int GAP_CYCLES = SB_GAP_CYCLES
) (
    input logic                 i_pll_clk,
    input logic                 i_rst,
    sb_rx_deserializer_if.slave sb
);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [GW-1:0] LAST_GAP = GW'(GAP_CYCLES - 1);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data;
    logic [BW-1:0]         r_bit_cnt;
    logic [GW-1:0]         r_gap_cnt;
    logic                  r_done;
    logic                  r_ferr;
    logic                  r_gerr;
    logic [DATA_WIDTH-1:0] w_shifted;

    assign w_shifted        = {r_shift[DATA_WIDTH-2:0], sb.RXDATASB};
    assign sb.o_data_out    = r_data;
    assign sb.o_de_ser_done = r_done;
    assign sb.o_frame_error = r_ferr;
    assign sb.o_gap_error   = r_gerr;

    // Strobes default low each edge so every pulse lasts exactly one cycle.
    always_ff @(posedge i_pll_clk) begin
        r_done <= 1'b0;
        r_ferr <= 1'b0;
        r_gerr <= 1'b0;
        if (i_rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_data    <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
        end else if (!sb.i_enable) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: if (sb.i_rx_valid) begin
                    r_shift   <= w_shifted;
                    r_bit_cnt <= BW'(1);
                    r_state   <= RECEIVE;
                end
                RECEIVE: if (sb.i_rx_valid) begin
                    r_shift <= w_shifted;
                    if (r_bit_cnt == LAST_BIT) begin
                        r_data    <= w_shifted;
                        r_done    <= 1'b1;
                        r_bit_cnt <= '0;
                        r_gap_cnt <= '0;
                        r_state   <= GAP;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end else begin
                    r_ferr    <= 1'b1;
                    r_shift   <= '0;
                    r_bit_cnt <= '0;
                    r_state   <= IDLE;
                end
                GAP: if (sb.i_rx_valid) begin
                    // Early bit is kept as the start of the next packet, only flagged.
                    r_gerr    <= 1'b1;
                    r_shift   <= w_shifted;
                    r_bit_cnt <= BW'(1);
                    r_gap_cnt <= '0;
                    r_state   <= RECEIVE;
                end else if (r_gap_cnt == LAST_GAP) begin
                    r_gap_cnt <= '0;
                    r_state   <= IDLE;
                end else begin
                    r_gap_cnt <= r_gap_cnt + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sb_rx_deserializer.sv
// tb_sb_rx_deserializer: scoreboard bench; expected strobes derived from packet timing rules.
module tb_sb_rx_deserializer;
    localparam int GAP = 32;
    localparam logic [2:0] K_DONE = 3'b100;
    localparam logic [2:0] K_FERR = 3'b010;
    localparam logic [2:0] K_GERR = 3'b001;

    typedef struct {
        logic [2:0]  kind;
        logic [63:0] data;
        int          e;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          edge_n = 0;
    int          total = 0;
    int          bad = 0;
    ev_t         q[$];
    logic [63:0] m_word = '0;
    int          m_last_done = -1000;

    sb_rx_deserializer_if sb();

    sb_rx_deserializer dut (
        .i_pll_clk(clk),
        .i_rst(rst),
        .sb(sb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    always @(negedge clk) begin
        logic [2:0] obs;
        ev_t ex;
        obs = {sb.o_de_ser_done, sb.o_frame_error, sb.o_gap_error};
        if (obs != 3'b000) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe edge=%0d got=%b want=none", edge_n, obs);
            end else begin
                ex = q.pop_front();
                if (obs !== ex.kind || edge_n != ex.e || sb.o_data_out !== ex.data) begin
                    bad++;
                    $display("FAIL strobe edge=%0d got kind=%b data=%h want kind=%b edge=%0d data=%h",
                             edge_n, obs, sb.o_data_out, ex.kind, ex.e, ex.data);
                end
            end
        end
    end

    task automatic push(input logic [2:0] k, input logic [63:0] d, input int e);
        ev_t ev;
        ev.kind = k;
        ev.data = d;
        ev.e    = e;
        q.push_back(ev);
    endtask

    task automatic cyc(input logic en, input logic v, input logic d);
        sb.i_enable   = en;
        sb.i_rx_valid = v;
        sb.RXDATASB   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) cyc(1'b1, 1'b0, 1'($urandom));
    endtask

    // mode 0: ends normally (frame error if short), 1: enable drop, 2: reset pulse
    task automatic send(input logic [63:0] w, input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            int e;
            e = edge_n + 1;
            if (i == 0 && e - m_last_done <= GAP) push(K_GERR, m_word, e);
            if (i == 63) begin
                m_word = w;
                m_last_done = e;
                push(K_DONE, w, e);
            end
            cyc(1'b1, 1'b1, w[63-i]);
        end
        if (n < 64) begin
            m_last_done = -1000;
            if (mode == 0) begin
                push(K_FERR, m_word, edge_n + 1);
                cyc(1'b1, 1'b0, 1'($urandom));
            end else if (mode == 1) begin
                cyc(1'b0, 1'($urandom), 1'($urandom));
            end else begin
                rst = 1'b1;
                m_word = '0;
                cyc(1'b1, 1'($urandom), 1'($urandom));
                rst = 1'b0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    initial begin
        sb.i_enable = 1'b1;
        sb.i_rx_valid = 1'b0;
        sb.RXDATASB = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'(i), 1'($urandom));
        chk("reset_data", sb.o_data_out, 64'h0);
        chk("reset_done", 64'(sb.o_de_ser_done), 64'h0);
        chk("reset_ferr", 64'(sb.o_frame_error), 64'h0);
        chk("reset_gerr", 64'(sb.o_gap_error), 64'h0);
        rst = 1'b0;
        idle(2);
        send(64'hA5A5_0000_FFFF_1234, 64, 0);
        idle(40);
        send(64'h1, 64, 0);
        idle(32);
        send(64'h8000_0000_0000_0000, 64, 0);
        idle(40);
        send(64'h1357_9BDF_0246_8ACE, 64, 0);
        idle(10);
        send(64'hDEAD_BEEF_CAFE_F00D, 64, 0);
        idle(40);
        send({$urandom, $urandom}, 40, 0);
        idle(2);
        send(64'h0123_4567_89AB_CDEF, 64, 0);
        idle(40);
        send({$urandom, $urandom}, 20, 1);
        idle(3);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64, 0);
        send(64'h0F0F_F0F0_5555_AAAA, 64, 0);
        idle(31);
        send({$urandom, $urandom}, 30, 2);
        idle(5);
        send({$urandom, $urandom}, 64, 0);
        idle(33);
        for (int t = 0; t < 30; t++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6) send({$urandom, $urandom}, 64, 0);
            else send({$urandom, $urandom}, int'($urandom_range(1, 63)), r - 6 > 2 ? 0 : r - 6);
            idle(int'($urandom_range(0, 40)));
        end
        idle(5);
        chk("queue_drained", 64'(q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
